iq_unpack: RTL and testbench

- Front-end producer for the complex FIR channel filter in the FM radio datapath.
- Pops a raw 8-bit byte stream (interleaved 16-bit little-endian I/Q pairs) from an input FIFO.
- Assembles each pair, sign-extends and quantizes it to DATA_WIDTH fixed point, and pushes I and Q into two separate output FIFOs.
- Those FIFOs feed the channel filter's real/imag inputs.

---
 rtl/iq_unpack_if.sv | 26 ++
 rtl/iq_unpack.sv | 87 ++++++++
 tb/tb_iq_unpack.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/iq_unpack_if.sv
// Byte-FIFO read side plus I/Q FIFO write sides of the sample unpacker.
// master = unpacker, slave = surrounding FIFOs (or a bench).
interface iq_unpack_if #(
  parameter int BYTE_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [BYTE_WIDTH-1:0] in_dout;
  logic                  in_empty;
  logic                  in_rd_en;
  logic [DATA_WIDTH-1:0] i_out;
  logic                  i_wr_en;
  logic                  i_full;
  logic [DATA_WIDTH-1:0] q_out;
  logic                  q_wr_en;
  logic                  q_full;

  modport master (
    input  in_dout, in_empty, i_full, q_full,
    output in_rd_en, i_out, i_wr_en, q_out, q_wr_en
  );

  modport slave (
    output in_dout, in_empty, i_full, q_full,
    input  in_rd_en, i_out, i_wr_en, q_out, q_wr_en
  );
endinterface

// File: rtl/iq_unpack.sv
// Unpacks interleaved 16-bit I/Q byte pairs into quantized I and Q FIFO pushes; IQ_UNPACK_BIG_ENDIAN_EN selects big-endian samples.
// 4 pop cycles then 1 write cycle per pair; a full I or Q FIFO holds the write and stops all input pops.
module iq_unpack #(
  parameter int DATA_WIDTH  = 32,
  parameter int BYTE_WIDTH  = 8,
  parameter int SAMPLE_BITS = 16,
  parameter int QUANT_BITS  = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  iq_unpack_if.master  bus
);

  typedef enum logic {READ, WRITE} state_t;

  state_t                          state;
  state_t                          state_nxt;
  logic [1:0]                      byte_cnt;
  logic [3:0][BYTE_WIDTH-1:0]      byte_buf;
  logic                            pop;
  logic                            push;
  logic [SAMPLE_BITS-1:0]          i_raw;
  logic [SAMPLE_BITS-1:0]          q_raw;
  logic [DATA_WIDTH-1:0]           i_quant;
  logic [DATA_WIDTH-1:0]           q_quant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= READ;
    end else begin
      state <= state_nxt;
    end
  end

  // byte_cnt wraps 3 -> 0 on the 4th pop, which is exactly the hand-off to WRITE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      byte_buf <= '0;
    end else if (pop) begin
      byte_buf[byte_cnt] <= bus.in_dout;
      byte_cnt           <= byte_cnt + 2'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    push      = 1'b0;
    case (state)
      READ: begin
        if (rst_n && !bus.in_empty) begin
          pop = 1'b1;
          if (byte_cnt == 2'd3) begin
            state_nxt = WRITE;
          end
        end
      end
      WRITE: begin
        if (!bus.i_full && !bus.q_full) begin
          push      = 1'b1;
          state_nxt = READ;
        end
      end
      default: state_nxt = READ;
    endcase
  end

`ifdef IQ_UNPACK_BIG_ENDIAN_EN
  assign i_raw = {byte_buf[0], byte_buf[1]};
  assign q_raw = {byte_buf[2], byte_buf[3]};
`else
  assign i_raw = {byte_buf[1], byte_buf[0]};
  assign q_raw = {byte_buf[3], byte_buf[2]};
`endif

  // Needs DATA_WIDTH >= SAMPLE_BITS + QUANT_BITS; no saturation is applied
  assign i_quant = {{(DATA_WIDTH-SAMPLE_BITS){i_raw[SAMPLE_BITS-1]}}, i_raw} << QUANT_BITS;
  assign q_quant = {{(DATA_WIDTH-SAMPLE_BITS){q_raw[SAMPLE_BITS-1]}}, q_raw} << QUANT_BITS;

  assign bus.in_rd_en = pop;
  assign bus.i_wr_en  = push;
  assign bus.q_wr_en  = push;
  assign bus.i_out    = push ? i_quant : '0;
  assign bus.q_out    = push ? q_quant : '0;

endmodule

// File: tb/tb_iq_unpack.sv
// Directed bench for iq_unpack: byte-source queue, per-cycle pair model, literal spot checks.
module tb_iq_unpack;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  iq_unpack_if #(.BYTE_WIDTH(8), .DATA_WIDTH(32)) bus();

  iq_unpack #(
    .DATA_WIDTH(32), .BYTE_WIDTH(8), .SAMPLE_BITS(16), .QUANT_BITS(10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  logic [7:0]  src[$];
  logic        rst_req = 1'b1;
  logic        gap     = 1'b0;
  logic        ifull   = 1'b0;
  logic        qfull   = 1'b0;
  int          n_cmp   = 0;
  int          n_bad   = 0;
  int          m_n     = 0;
  logic [7:0]  m_b[4];
  int          wr_count = 0;
  int          rd_count = 0;
  logic [31:0] last_i   = '0;
  logic [31:0] last_q   = '0;

  // Signed 16-bit sample times 2^10, as a 32-bit word
  function automatic logic [31:0] quant(input logic [7:0] lo, input logic [7:0] hi);
    logic [15:0] raw;
    int v;
    raw = {hi, lo};
    v   = int'($signed(raw));
    return 32'(v * 1024);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic        exp_rd;
    logic        exp_wr;
    logic [31:0] ei;
    logic [31:0] eq;
    @(negedge clk);
    rst_n        = !rst_req;
    bus.in_empty = gap || (src.size() == 0);
    bus.in_dout  = (src.size() != 0) ? src[0] : 8'h00;
    bus.i_full   = ifull;
    bus.q_full   = qfull;
    #2;
    exp_rd = rst_n && (m_n < 4) && !bus.in_empty;
    exp_wr = rst_n && (m_n == 4) && !ifull && !qfull;
    ei = '0;
    eq = '0;
    if (exp_wr) begin
`ifdef IQ_UNPACK_BIG_ENDIAN_EN
      ei = quant(m_b[1], m_b[0]);
      eq = quant(m_b[3], m_b[2]);
`else
      ei = quant(m_b[0], m_b[1]);
      eq = quant(m_b[2], m_b[3]);
`endif
    end
    chk("in_rd_en", 32'(bus.in_rd_en), 32'(exp_rd));
    chk("i_wr_en",  32'(bus.i_wr_en),  32'(exp_wr));
    chk("q_wr_en",  32'(bus.q_wr_en),  32'(exp_wr));
    chk("i_out",    bus.i_out, ei);
    chk("q_out",    bus.q_out, eq);
    if (bus.i_wr_en) begin
      wr_count++;
      last_i = bus.i_out;
      last_q = bus.q_out;
    end
    if (bus.in_rd_en) begin
      rd_count++;
      if (src.size() != 0) void'(src.pop_front());
    end
    if (exp_rd) begin
      m_b[m_n] = bus.in_dout;
      m_n++;
    end
    if (exp_wr || !rst_n) m_n = 0;
  endtask

  // Runs until the source is empty and no pair is pending; returns cycles used
  task automatic drain(input int budget, input bit gappy, output int cycles);
    int k;
    k = 0;
    while ((src.size() != 0 || m_n != 0) && k < budget) begin
      gap = gappy && (k % 2 == 0);
      tick();
      k++;
    end
    gap = 1'b0;
    chk("drain_done", 32'(src.size() == 0 && m_n == 0), 32'd1);
    cycles = k;
  endtask

  task automatic push4(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    src.push_back(b0);
    src.push_back(b1);
    src.push_back(b2);
    src.push_back(b3);
  endtask

  initial begin
    int wr0;
    int rd0;
    int cyc;
    logic [31:0] e1_i, e1_q, e2_i, e2_q, e3_i, e3_q;
`ifdef IQ_UNPACK_BIG_ENDIAN_EN
    e1_i = 32'h00D04800; e1_q = 32'hFFFFFC00;
    e2_i = 32'h00020000; e2_q = 32'hFFFDFC00;
    e3_i = 32'h00040000; e3_q = 32'h00080000;
`else
    e1_i = 32'h0048D000; e1_q = 32'hFFFFFC00;
    e2_i = 32'hFE000000; e2_q = 32'h01FFFC00;
    e3_i = 32'h00000400; e3_q = 32'h00000800;
`endif

    // Reset with a byte waiting: nothing may be popped or written
    src.push_back(8'hAA);
    rst_req = 1'b1;
    repeat (3) tick();
    chk("rst_rd_en", 32'(bus.in_rd_en), 32'd0);
    chk("rst_i_out", bus.i_out, 32'd0);
    chk("rst_q_out", bus.q_out, 32'd0);
    src.delete();
    rst_req = 1'b0;
    repeat (2) tick();

    // Single little/big-endian pair: 4 pops then one write, 5 cycles total
    wr0 = wr_count; rd0 = rd_count;
    push4(8'h34, 8'h12, 8'hFF, 8'hFF);
    drain(20, 1'b0, cyc);
    chk("pair_cycles", 32'(cyc), 32'd5);
    chk("pair_writes", 32'(wr_count - wr0), 32'd1);
    chk("pair_pops",   32'(rd_count - rd0), 32'd4);
    chk("pair_i", last_i, e1_i);
    chk("pair_q", last_q, e1_q);

    // Negative extreme
    push4(8'h00, 8'h80, 8'hFF, 8'h7F);
    drain(20, 1'b0, cyc);
    chk("neg_i", last_i, e2_i);
    chk("neg_q", last_q, e2_q);

    // Starvation: bytes only every other cycle, result identical to gap-free
    wr0 = wr_count; rd0 = rd_count;
    push4(8'h34, 8'h12, 8'hFF, 8'hFF);
    drain(40, 1'b1, cyc);
    chk("starve_writes", 32'(wr_count - wr0), 32'd1);
    chk("starve_pops",   32'(rd_count - rd0), 32'd4);
    chk("starve_i", last_i, e1_i);
    chk("starve_q", last_q, e1_q);

    // Backpressure: i_full then q_full held 6 cycles in WRITE, next pair waiting
    push4(8'h01, 8'h00, 8'h02, 8'h00);
    push4(8'h00, 8'h80, 8'hFF, 8'h7F);
    ifull = 1'b1;
    repeat (4) tick();
    wr0 = wr_count; rd0 = rd_count;
    repeat (6) tick();
    chk("ifull_no_write", 32'(wr_count - wr0), 32'd0);
    chk("ifull_no_pop",   32'(rd_count - rd0), 32'd0);
    ifull = 1'b0;
    tick();
    chk("ifull_release_write", 32'(wr_count - wr0), 32'd1);
    chk("ifull_i", last_i, e3_i);
    qfull = 1'b1;
    repeat (4) tick();
    wr0 = wr_count; rd0 = rd_count;
    repeat (6) tick();
    chk("qfull_no_write", 32'(wr_count - wr0), 32'd0);
    chk("qfull_no_pop",   32'(rd_count - rd0), 32'd0);
    qfull = 1'b0;
    tick();
    chk("qfull_release_write", 32'(wr_count - wr0), 32'd1);
    chk("qfull_q", last_q, e2_q);
    drain(20, 1'b0, cyc);

    // Reset mid-sample discards the two bytes already taken
    src.push_back(8'h55);
    src.push_back(8'h66);
    repeat (2) tick();
    wr0 = wr_count;
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    push4(8'h01, 8'h00, 8'h02, 8'h00);
    drain(20, 1'b0, cyc);
    chk("rst_mid_writes", 32'(wr_count - wr0), 32'd1);
    chk("rst_mid_i", last_i, e3_i);
    chk("rst_mid_q", last_q, e3_q);
    repeat (2) tick();

    // Throughput: 100 random pairs in 500 cycles
    for (int p = 0; p < 400; p++) src.push_back(8'($urandom_range(0, 255)));
    wr0 = wr_count;
    repeat (500) tick();
    chk("thru_writes", 32'(wr_count - wr0), 32'd100);
    chk("thru_consumed", 32'(src.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
